// File: rtl/aibnd_red_pkg.sv
// Shared types and default parameters for the redundancy shift control slice.
package aibnd_red_pkg;

  localparam int unsigned NPAD_DEF        = 24;
  localparam int unsigned IDX_W_DEF       = 5;
  localparam int unsigned QUIESCE_CYC_DEF = 4;
  localparam int unsigned SETTLE_CYC_DEF  = 8;
  localparam int unsigned CNT_W_DEF       = 4;

  // Sequencer phases; encodings kept fixed so state dumps match the legacy block.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    APPLY   = 2'd2,
    SETTLE  = 2'd3
  } red_state_t;

endpackage

// File: rtl/aibnd_red_therm_dec.sv
// Failing-pad index to thermometer shift-vector decoder with range check.
module aibnd_red_therm_dec
  import aibnd_red_pkg::*;
#(
  parameter int unsigned NPAD  = NPAD_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             i_red_en,
  input  logic [IDX_W-1:0] i_fail_idx,
  output logic [NPAD-1:0]  o_therm,
  output logic             o_oor
);

  // Every pad at or above the failing index shifts; nothing shifts when disabled.
  always_comb begin
    o_therm = '0;
    o_oor   = i_red_en && (32'(i_fail_idx) >= NPAD);
    for (int unsigned i = 0; i < NPAD; i++) begin
      o_therm[i] = i_red_en && (i >= 32'(i_fail_idx));
    end
  end

endmodule

// File: rtl/aibnd_red_shift_ctrl.sv
// Redundancy clock-mux control: accepts configuration requests and applies
// them behind a gate / apply / settle sequence so mux selects only move
// while downstream clocks are gated.
module aibnd_red_shift_ctrl
  import aibnd_red_pkg::*;
#(
  parameter int unsigned NPAD        = NPAD_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF,
  parameter int unsigned QUIESCE_CYC = QUIESCE_CYC_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic             i_cfg_red_en,
  input  logic [IDX_W-1:0] i_cfg_fail_idx,
  input  logic             i_cfg_jtag_clksel,
  output logic [NPAD-1:0]  o_shift_en,
  output logic             o_jtag_clksel,
  output logic             o_clk_gate_en,
  output logic             o_busy,
  output logic             o_cfg_err
);

  red_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [NPAD-1:0]  r_pend_shift;
  logic             r_pend_jtag;
  logic [NPAD-1:0]  r_shift_en;
  logic             r_jtag_clksel;
  logic             r_clk_gate_en;
  logic             r_busy;
  logic             r_cfg_ready;
  logic             r_cfg_err;

  logic [NPAD-1:0]  w_therm;
  logic             w_oor;
  logic             w_accept;
  logic             w_noop;

  aibnd_red_therm_dec #(
    .NPAD  (NPAD),
    .IDX_W (IDX_W)
  ) u_dec (
    .i_red_en   (i_cfg_red_en),
    .i_fail_idx (i_cfg_fail_idx),
    .o_therm    (w_therm),
    .o_oor      (w_oor)
  );

  // Handshake qualification: ready is only ever high in IDLE.
  always_comb begin
    w_accept = i_cfg_valid && r_cfg_ready;
    w_noop   = (w_therm == r_shift_en) && (i_cfg_jtag_clksel == r_jtag_clksel);
  end

  // Sequencer: gate clocks, wait, swap selects, wait, ungate.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_pend_shift  <= '0;
      r_pend_jtag   <= 1'b0;
      r_shift_en    <= '0;
      r_jtag_clksel <= 1'b0;
      r_clk_gate_en <= 1'b1;
      r_busy        <= 1'b0;
      r_cfg_ready   <= 1'b1;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_oor) begin
              r_cfg_err <= 1'b1;
            end else if (!w_noop) begin
              r_pend_shift  <= w_therm;
              r_pend_jtag   <= i_cfg_jtag_clksel;
              r_state       <= QUIESCE;
              r_cnt         <= CNT_W'(QUIESCE_CYC - 1);
              r_clk_gate_en <= 1'b0;
              r_busy        <= 1'b1;
              r_cfg_ready   <= 1'b0;
            end
          end
        end
        QUIESCE: begin
          if (r_cnt == '0) begin
            r_state <= APPLY;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        APPLY: begin
          r_shift_en    <= r_pend_shift;
          r_jtag_clksel <= r_pend_jtag;
          r_state       <= SETTLE;
          r_cnt         <= CNT_W'(SETTLE_CYC - 1);
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_state       <= IDLE;
            r_clk_gate_en <= 1'b1;
            r_busy        <= 1'b0;
            r_cfg_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cfg_ready   = r_cfg_ready;
  assign o_shift_en    = r_shift_en;
  assign o_jtag_clksel = r_jtag_clksel;
  assign o_clk_gate_en = r_clk_gate_en;
  assign o_busy        = r_busy;
  assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_aibnd_red_shift_ctrl.sv
// Bench for aibnd_red_shift_ctrl: directed scenarios then random traffic,
// each cycle compared against a time-offset reference model.
module tb_aibnd_red_shift_ctrl;

  localparam int unsigned NPAD  = 24;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned QC    = 4;
  localparam int unsigned SC    = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic             cfg_red_en = 1'b0;
  logic [IDX_W-1:0] cfg_fail_idx = '0;
  logic             cfg_jtag_clksel = 1'b0;
  logic [NPAD-1:0]  shift_en;
  logic             jtag_clksel;
  logic             clk_gate_en;
  logic             busy;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: a change runs for a fixed span after acceptance.
  int unsigned     n = 0;
  bit              m_active = 0;
  int unsigned     m_t0 = 0;
  logic [NPAD-1:0] m_shift = '0;
  logic            m_jtag = 1'b0;
  logic [NPAD-1:0] m_pshift = '0;
  logic            m_pjtag = 1'b0;
  logic            m_err = 1'b0;

  aibnd_red_shift_ctrl #(
    .NPAD        (NPAD),
    .IDX_W       (IDX_W),
    .QUIESCE_CYC (QC),
    .SETTLE_CYC  (SC),
    .CNT_W       (4)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_cfg_valid       (cfg_valid),
    .o_cfg_ready       (cfg_ready),
    .i_cfg_red_en      (cfg_red_en),
    .i_cfg_fail_idx    (cfg_fail_idx),
    .i_cfg_jtag_clksel (cfg_jtag_clksel),
    .o_shift_en        (shift_en),
    .o_jtag_clksel     (jtag_clksel),
    .o_clk_gate_en     (clk_gate_en),
    .o_busy            (busy),
    .o_cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input bit red, input int unsigned idx,
                            input bit jt, input bit rst);
    logic [NPAD-1:0] ones;
    logic [NPAD-1:0] th;
    int unsigned     k;
    ones = '1;
    n++;
    if (rst) begin
      m_active = 0;
      m_shift  = '0;
      m_jtag   = 1'b0;
      m_err    = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_active) begin
        k = n - m_t0;
        if (k == QC + 1) begin
          m_shift = m_pshift;
          m_jtag  = m_pjtag;
        end
        if (k == QC + 1 + SC) m_active = 0;
      end else if (v) begin
        if (red && idx >= NPAD) begin
          m_err = 1'b1;
        end else begin
          th = red ? (ones << idx) : '0;
          if (!(th == m_shift && jt == m_jtag)) begin
            m_active = 1;
            m_t0     = n;
            m_pshift = th;
            m_pjtag  = jt;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("shift_en",    32'(shift_en),    32'(m_shift));
    chk("jtag_clksel", 32'(jtag_clksel), 32'(m_jtag));
    chk("clk_gate_en", 32'(clk_gate_en), 32'(!m_active));
    chk("busy",        32'(busy),        32'(m_active));
    chk("cfg_ready",   32'(cfg_ready),   32'(!m_active));
    chk("cfg_err",     32'(cfg_err),     32'(m_err));
  endtask

  task automatic step(input bit v, input bit red, input int unsigned idx,
                      input bit jt, input bit rst);
    cfg_valid       = v;
    cfg_red_en      = red;
    cfg_fail_idx    = IDX_W'(idx);
    cfg_jtag_clksel = jt;
    reset           = rst;
    @(posedge clk);
    model_edge(v, red, idx, jt, rst);
    #1;
    check_all();
  endtask

  initial begin
    // Reset, then idle.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("rst_shift", 32'(shift_en), 32'h0);
    chk("rst_gate",  32'(clk_gate_en), 32'h1);
    chk("rst_ready", 32'(cfg_ready), 32'h1);

    // idx=5 accepted at edge T; outputs move at T+5, gate returns at T+13.
    step(1, 1, 5, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 0, 0);
      if (k == 4) chk("t4_shift_old", 32'(shift_en), 32'h0);
      if (k == 5) chk("t5_shift_new", 32'(shift_en), 32'hFFFFE0);
    end
    chk("t12_gate_low", 32'(clk_gate_en), 32'h0);
    step(0, 0, 0, 0, 0);
    chk("t13_gate_high", 32'(clk_gate_en), 32'h1);
    chk("t13_ready",     32'(cfg_ready),   32'h1);

    // Same request again: no-op, no gating.
    step(1, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("noop_gate", 32'(clk_gate_en), 32'h1);
    chk("noop_busy", 32'(busy), 32'h0);

    // Out-of-range index rejected, then idx=23 applied.
    step(1, 1, 24, 0, 0);
    chk("rej_err", 32'(cfg_err), 32'h1);
    step(0, 0, 0, 0, 0);
    chk("rej_err_clear", 32'(cfg_err), 32'h0);
    chk("rej_shift", 32'(shift_en), 32'hFFFFE0);
    step(1, 1, 23, 1, 0);
    // Hold a different request through the sequence; accepted only after ready.
    for (int k = 0; k < 34; k++) step(1, 0, 9, 0, 0);
    chk("red_off_shift", 32'(shift_en), 32'h0);
    chk("red_off_jtag",  32'(jtag_clksel), 32'h0);

    // Reset at T+3 drops the pending request.
    step(1, 1, 10, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("mid_rst_gate", 32'(clk_gate_en), 32'h1);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0);
    chk("mid_rst_never_applied", 32'(shift_en), 32'h0);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      int unsigned idx;
      bit v;
      bit rst;
      v   = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 1) == 1) idx = $urandom_range(0, 31);
      else begin
        case ($urandom_range(0, 3))
          0: idx = 0;
          1: idx = 5;
          2: idx = 23;
          default: idx = 24;
        endcase
      end
      step(v, bit'($urandom_range(0, 1)), idx, bit'($urandom_range(0, 1)), rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
